fetch_sequencer: RTL and testbench

- Sequences instruction fetch into instruction_reg for the 8-bit pipelined core.
- Drives the byte-wide instruction memory handshake and owns the PC.
- Generates ir_ld / ir_new / sf1 for one- and two-byte instructions; sf1=1 marks the second (operand) byte.
- Handles pipeline stall, branch redirect (IR flush) and HALT.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_perf_counters.sv | 36 +++
 rtl/fetch_sequencer.sv | 91 +++++++++
 tb/tb_fetch_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer slice.
package fetch_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 8;
  localparam int unsigned PERF_W         = 16;

  typedef enum logic [1:0] {
    F1     = 2'd0,
    F2     = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_perf_counters.sv
// Two saturating event counters for fetch performance monitoring.
module fetch_perf_counters
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_inc,
  input  logic              stall_inc,
  output logic [PERF_W-1:0] perf_instr,
  output logic [PERF_W-1:0] perf_stall
);

  logic [PERF_W-1:0] instr_q, instr_d;
  logic [PERF_W-1:0] stall_q, stall_d;

  always_comb begin
    instr_d = instr_q;
    stall_d = stall_q;
    if (instr_inc && (instr_q != '1)) instr_d = instr_q + PERF_W'(1);
    if (stall_inc && (stall_q != '1)) stall_d = stall_q + PERF_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      stall_q <= '0;
    end else begin
      instr_q <= instr_d;
      stall_q <= stall_d;
    end
  end

  assign perf_instr = instr_q;
  assign perf_stall = stall_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, drives the byte-wide imem handshake and IR loads.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_rdata,
  input  logic              imem_valid,
  input  logic              long_op,
  input  logic              halt_op,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [7:0]        ir_new,
  output logic              ir_ld,
  output logic              sf1_out,
  output logic              ir_flush,
  output logic              halted
`ifdef FETCH_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_instr,
  output logic [PERF_W-1:0] perf_stall
`endif
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fetching;
  logic              accept;

  assign fetching = (state_q != HALTED);
  // Outputs are forced low while reset is asserted.
  assign imem_req  = !rst && fetching && !stall && !redirect;
  assign accept    = imem_req && imem_valid;
  assign imem_addr = rst ? '0 : pc_q;
  assign ir_ld     = accept;
  assign ir_new    = accept ? imem_rdata : 8'h00;
  assign sf1_out   = accept && (state_q == F2);
  assign ir_flush  = !rst && redirect;
  assign halted    = !rst && (state_q == HALTED);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect) begin
      state_d = F1;
      pc_d    = redirect_pc;
    end else if (accept) begin
      pc_d = pc_q + ADDR_W'(1);
      if (state_q == F2)  state_d = F1;
      else if (halt_op)   state_d = HALTED;
      else if (long_op)   state_d = F2;
      else                state_d = F1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= F1;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic instr_done;
  logic stall_cycle;

  // HALT is a one-byte instruction and counts as completed.
  assign instr_done  = accept && ((state_q == F2) || halt_op || !long_op);
  assign stall_cycle = !rst && fetching && stall;

  fetch_perf_counters u_perf (
    .clk        (clk),
    .rst        (rst),
    .instr_inc  (instr_done),
    .stall_inc  (stall_cycle),
    .perf_instr (perf_instr),
    .perf_stall (perf_stall)
  );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized model comparison.
module tb_fetch_sequencer;

  logic       clk;
  logic       rst;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       imem_valid;
  logic       long_op;
  logic       halt_op;
  logic       stall;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic [7:0] ir_new;
  logic       ir_ld;
  logic       sf1_out;
  logic       ir_flush;
  logic       halted;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_instr;
  logic [15:0] perf_stall;
`endif

  int total;
  int passed;

  // Reference model: address of next byte, whether the next byte is an operand, halted flag.
  logic [7:0] m_pc;
  bit         m_second;
  bit         m_halted;
  int         m_instr;
  int         m_stall;

  fetch_sequencer #(
    .ADDR_W   (8),
    .RESET_PC (8'h10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .long_op     (long_op),
    .halt_op     (halt_op),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ir_new      (ir_new),
    .ir_ld       (ir_ld),
    .sf1_out     (sf1_out),
    .ir_flush    (ir_flush),
    .halted      (halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_instr  (perf_instr),
    .perf_stall  (perf_stall)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Apply inputs at the falling edge and let combinational outputs settle.
  task automatic set_in(input bit v, input logic [7:0] d, input bit lo, input bit ha,
                        input bit st, input bit rd, input logic [7:0] rpc);
    imem_valid  = v;
    imem_rdata  = d;
    long_op     = lo;
    halt_op     = ha;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
  endtask

  // Advance one clock and update the reference model from the applied inputs.
  task automatic tick();
    bit acc;
    acc = !m_halted && !stall && !redirect && imem_valid;
    if (stall && !m_halted && m_stall < 65535) m_stall++;
    if (acc && (m_second || halt_op || !long_op) && m_instr < 65535) m_instr++;
    if (redirect) begin
      m_pc     = redirect_pc;
      m_second = 0;
      m_halted = 0;
    end else if (acc) begin
      m_pc = m_pc + 8'd1;
      if (m_second)     m_second = 0;
      else if (halt_op) m_halted = 1;
      else if (long_op) m_second = 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(1, 8'hAB, 1, 0, 0, 1, 8'h33);
    @(negedge clk);
    @(negedge clk);
    m_pc = 8'h10; m_second = 0; m_halted = 0; m_instr = 0; m_stall = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({imem_req, imem_addr, ir_new, ir_ld, sf1_out, ir_flush, halted} !== 21'd0)
      $display("FAIL reset_outputs: got req=%b addr=%h new=%h ld=%b sf1=%b flush=%b halted=%b, want all 0",
               imem_req, imem_addr, ir_new, ir_ld, sf1_out, ir_flush, halted);
    else passed++;
    rst = 1'b0;
    set_in(0, 8'h00, 0, 0, 0, 0, 8'h00);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h10)
      $display("FAIL reset_release: got req=%b addr=%h, want 1 10", imem_req, imem_addr);
    else passed++;
    total++;
    if ({ir_ld, sf1_out, ir_flush, halted, ir_new} !== 12'd0)
      $display("FAIL reset_idle: got ld=%b sf1=%b flush=%b halted=%b new=%h, want 0",
               ir_ld, sf1_out, ir_flush, halted, ir_new);
    else passed++;
`ifdef FETCH_PERF_EN
    total++;
    if (perf_instr !== 16'd0 || perf_stall !== 16'd0)
      $display("FAIL reset_perf: got %h %h, want 0 0", perf_instr, perf_stall);
    else passed++;
`endif
  endtask

  task automatic test_sequence();
    logic [7:0] bytes [3] = '{8'h21, 8'hC5, 8'h7E};
    bit         longs [3] = '{0, 1, 0};
    bit         sf1s  [3] = '{0, 0, 1};
    for (int i = 0; i < 3; i++) begin
      set_in(1, bytes[i], longs[i], 0, 0, 0, 8'h00);
      total++;
      if (ir_ld !== 1'b1 || ir_new !== bytes[i] || sf1_out !== sf1s[i] ||
          imem_addr !== 8'h10 + 8'(i))
        $display("FAIL seq_byte%0d: got ld=%b new=%h sf1=%b addr=%h, want 1 %h %b %h",
                 i, ir_ld, ir_new, sf1_out, imem_addr, bytes[i], sf1s[i], 8'h10 + 8'(i));
      else passed++;
      tick();
    end
    set_in(1, 8'h33, 0, 0, 0, 0, 8'h00);
    total++;
    if (imem_addr !== 8'h13 || sf1_out !== 1'b0 || ir_ld !== 1'b1)
      $display("FAIL seq_end: got addr=%h sf1=%b ld=%b, want 13 0 1", imem_addr, sf1_out, ir_ld);
    else passed++;
    tick();
  endtask

  task automatic test_redirect_f2();
    set_in(0, 8'h00, 0, 0, 0, 1, 8'h40);
    tick();
    set_in(1, 8'h99, 1, 0, 0, 0, 8'h00);
    total++;
    if (imem_addr !== 8'h40 || ir_ld !== 1'b1 || sf1_out !== 1'b0)
      $display("FAIL redir_long: got addr=%h ld=%b sf1=%b, want 40 1 0", imem_addr, ir_ld, sf1_out);
    else passed++;
    tick();
    set_in(1, 8'h55, 0, 0, 0, 1, 8'h80);
    total++;
    if (ir_flush !== 1'b1 || ir_ld !== 1'b0 || imem_req !== 1'b0)
      $display("FAIL redir_flush: got flush=%b ld=%b req=%b, want 1 0 0", ir_flush, ir_ld, imem_req);
    else passed++;
    tick();
    set_in(1, 8'h11, 0, 0, 0, 0, 8'h00);
    total++;
    if (imem_addr !== 8'h80 || ir_flush !== 1'b0 || sf1_out !== 1'b0 || ir_new !== 8'h11)
      $display("FAIL redir_target: got addr=%h flush=%b sf1=%b new=%h, want 80 0 0 11",
               imem_addr, ir_flush, sf1_out, ir_new);
    else passed++;
    tick();
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 8'hAA, 0, 0, 1, 0, 8'h00);
      total++;
      if (imem_req !== 1'b0 || ir_ld !== 1'b0 || imem_addr !== 8'h81)
        $display("FAIL stall_hold%0d: got req=%b ld=%b addr=%h, want 0 0 81",
                 i, imem_req, ir_ld, imem_addr);
      else passed++;
      tick();
    end
    set_in(1, 8'hAA, 0, 0, 0, 0, 8'h00);
    total++;
    if (imem_req !== 1'b1 || ir_ld !== 1'b1 || imem_addr !== 8'h81 || ir_new !== 8'hAA)
      $display("FAIL stall_resume: got req=%b ld=%b addr=%h new=%h, want 1 1 81 AA",
               imem_req, ir_ld, imem_addr, ir_new);
    else passed++;
    tick();
    set_in(1, 8'hBB, 0, 0, 1, 1, 8'h20);
    total++;
    if (ir_flush !== 1'b1 || imem_req !== 1'b0)
      $display("FAIL stall_redir: got flush=%b req=%b, want 1 0", ir_flush, imem_req);
    else passed++;
    tick();
    set_in(0, 8'h00, 0, 0, 0, 0, 8'h00);
    total++;
    if (imem_addr !== 8'h20 || ir_flush !== 1'b0)
      $display("FAIL stall_redir_pc: got addr=%h flush=%b, want 20 0", imem_addr, ir_flush);
    else passed++;
  endtask

  task automatic test_halt_wrap();
    // Long op at FF: its operand byte must come from address 00.
    set_in(0, 8'h00, 0, 0, 0, 1, 8'hFF);
    tick();
    set_in(1, 8'hC0, 1, 0, 0, 0, 8'h00);
    tick();
    set_in(1, 8'h01, 0, 0, 0, 0, 8'h00);
    total++;
    if (imem_addr !== 8'h00 || sf1_out !== 1'b1 || ir_ld !== 1'b1)
      $display("FAIL wrap_f2: got addr=%h sf1=%b ld=%b, want 00 1 1", imem_addr, sf1_out, ir_ld);
    else passed++;
    tick();
    set_in(0, 8'h00, 0, 0, 0, 1, 8'hFF);
    tick();
    set_in(1, 8'h76, 1, 1, 0, 0, 8'h00);
    total++;
    if (imem_addr !== 8'hFF || ir_ld !== 1'b1 || ir_new !== 8'h76)
      $display("FAIL halt_accept: got addr=%h ld=%b new=%h, want FF 1 76", imem_addr, ir_ld, ir_new);
    else passed++;
    tick();
    for (int i = 0; i < 10; i++) begin
      set_in(1, 8'h00, 0, 0, 0, 0, 8'h00);
      total++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || ir_ld !== 1'b0 || imem_addr !== 8'h00)
        $display("FAIL halted%0d: got halted=%b req=%b ld=%b addr=%h, want 1 0 0 00",
                 i, halted, imem_req, ir_ld, imem_addr);
      else passed++;
      tick();
    end
    set_in(0, 8'h00, 0, 0, 0, 1, 8'h05);
    total++;
    if (ir_flush !== 1'b1)
      $display("FAIL halt_redir_flush: got %b, want 1", ir_flush);
    else passed++;
    tick();
    set_in(1, 8'h42, 0, 0, 0, 0, 8'h00);
    total++;
    if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h05 || ir_ld !== 1'b1)
      $display("FAIL halt_exit: got halted=%b req=%b addr=%h ld=%b, want 0 1 05 1",
               halted, imem_req, imem_addr, ir_ld);
    else passed++;
    tick();
  endtask

  task automatic test_random();
    bit         v, lo, ha, st, rd;
    logic [7:0] d, rpc;
    bit         exp_req, exp_acc;
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 99) < 70);
      d   = 8'($urandom);
      lo  = ($urandom_range(0, 99) < 30);
      ha  = ($urandom_range(0, 99) < 5);
      st  = ($urandom_range(0, 99) < 20);
      rd  = ($urandom_range(0, 99) < 6);
      rpc = 8'($urandom);
      set_in(v, d, lo, ha, st, rd, rpc);
      exp_req = !m_halted && !st && !rd;
      exp_acc = exp_req && v;
      total++;
      if (imem_req !== exp_req || imem_addr !== m_pc || ir_ld !== exp_acc ||
          ir_new !== (exp_acc ? d : 8'h00) || sf1_out !== (exp_acc && m_second) ||
          ir_flush !== rd || halted !== m_halted)
        $display("FAIL rand%0d: got req=%b addr=%h ld=%b new=%h sf1=%b flush=%b halted=%b, want %b %h %b %h %b %b %b",
                 i, imem_req, imem_addr, ir_ld, ir_new, sf1_out, ir_flush, halted,
                 exp_req, m_pc, exp_acc, exp_acc ? d : 8'h00, exp_acc && m_second, rd, m_halted);
      else passed++;
`ifdef FETCH_PERF_EN
      total++;
      if (perf_instr !== 16'(m_instr) || perf_stall !== 16'(m_stall))
        $display("FAIL rand_perf%0d: got %0d %0d, want %0d %0d",
                 i, perf_instr, perf_stall, m_instr, m_stall);
      else passed++;
`endif
      tick();
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    do_reset();
    rst = 1'b0;
    set_in(1, 8'h01, 0, 0, 0, 0, 8'h00); tick();
    set_in(1, 8'h02, 0, 0, 1, 0, 8'h00); tick();
    set_in(1, 8'h02, 0, 0, 1, 0, 8'h00); tick();
    set_in(1, 8'h02, 0, 0, 0, 0, 8'h00); tick();
    set_in(1, 8'h03, 1, 0, 1, 0, 8'h00); tick();
    set_in(1, 8'h03, 1, 0, 0, 0, 8'h00); tick();
    set_in(1, 8'h04, 0, 0, 1, 0, 8'h00); tick();
    set_in(1, 8'h04, 0, 0, 0, 0, 8'h00); tick();
    set_in(0, 8'h00, 0, 0, 0, 0, 8'h00);
    total++;
    if (perf_instr !== 16'd3 || perf_stall !== 16'd4)
      $display("FAIL perf_counts: got instr=%0d stall=%0d, want 3 4", perf_instr, perf_stall);
    else passed++;
    set_in(1, 8'h00, 0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 65540; i++) tick();
    total++;
    if (perf_stall !== 16'hFFFF || perf_instr !== 16'd3)
      $display("FAIL perf_saturate: got stall=%h instr=%0d, want FFFF 3", perf_stall, perf_instr);
    else passed++;
  endtask
`endif

  initial begin
    total = 0;
    passed = 0;
    rst = 1'b1;
    set_in(0, 8'h00, 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    test_reset();
    test_sequence();
    test_redirect_f2();
    test_stall();
    test_halt_wrap();
    test_random();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
